// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: source identifiers,
// default sizing and the buffered result entry.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_MUL = 2'd0,
        SRC_AM  = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    localparam int unsigned NUM_SRC        = 3;
    localparam int unsigned DEFAULT_DEPTH  = 2;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;

    // One buffered write-back result at the default widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] regdest;
        logic [DEFAULT_DATA_W-1:0] wbvalue;
    } wb_entry_t;

    // Successor in the fixed arbitration ring MUL -> AM -> MEM -> MUL.
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_MUL: return SRC_AM;
            SRC_AM:  return SRC_MEM;
            default: return SRC_MUL;
        endcase
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO: synchronous push/pop, occupancy count and
// full/empty flags. A push while full is accepted only with a same-cycle pop.
module wb_src_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; when full with a pop, wr_ptr equals rd_ptr and the
    // head is read out combinationally before this edge overwrites it.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between Mult, AluMisc and Mem.
// Each source buffers results in its own FIFO; one head per cycle is
// granted round-robin and registered onto the write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mul_wb_oper,
    input  logic              mul_wb_writereg,
    input  logic [ADDR_W-1:0] mul_wb_regdest,
    input  logic [DATA_W-1:0] mul_wb_wbvalue,
    input  logic              am_wb_oper,
    input  logic              am_wb_writereg,
    input  logic [ADDR_W-1:0] am_wb_regdest,
    input  logic [DATA_W-1:0] am_wb_wbvalue,
    input  logic              mem_wb_oper,
    input  logic              mem_wb_writereg,
    input  logic [ADDR_W-1:0] mem_wb_regdest,
    input  logic [DATA_W-1:0] mem_wb_wbvalue,
    output logic              wb_mul_full,
    output logic              wb_am_full,
    output logic              wb_mem_full,
    output logic              wb_reg_en,
    output logic [ADDR_W-1:0] wb_reg_addr,
    output logic [DATA_W-1:0] wb_reg_data,
    output logic              wb_busy,
    output logic              wb_overflow
);

    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] regdest;
        logic [DATA_W-1:0] wbvalue;
    } wb_ent_t;

    wb_ent_t            push_ent [NUM_SRC];
    wb_ent_t            head     [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;

    src_e last_q;
    src_e grant;
    src_e cand1, cand2, cand3;
    logic grant_valid;

    // Stores (oper without writereg) never enter a FIFO.
    assign push[SRC_MUL] = mul_wb_oper & mul_wb_writereg;
    assign push[SRC_AM]  = am_wb_oper  & am_wb_writereg;
    assign push[SRC_MEM] = mem_wb_oper & mem_wb_writereg;

    assign push_ent[SRC_MUL] = {mul_wb_regdest, mul_wb_wbvalue};
    assign push_ent[SRC_AM]  = {am_wb_regdest,  am_wb_wbvalue};
    assign push_ent[SRC_MEM] = {mem_wb_regdest, mem_wb_wbvalue};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        wb_src_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (push_ent[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign wb_mul_full = full[SRC_MUL];
    assign wb_am_full  = full[SRC_AM];
    assign wb_mem_full = full[SRC_MEM];
    assign wb_busy     = (~&empty) | wb_reg_en;

    // Round-robin grant: search the ring starting after the last winner.
    always_comb begin
        cand1       = next_src(last_q);
        cand2       = next_src(cand1);
        cand3       = next_src(cand2);
        grant_valid = 1'b0;
        grant       = last_q;
        pop         = '0;
        if (!empty[cand1]) begin
            grant_valid = 1'b1;
            grant       = cand1;
        end else if (!empty[cand2]) begin
            grant_valid = 1'b1;
            grant       = cand2;
        end else if (!empty[cand3]) begin
            grant_valid = 1'b1;
            grant       = cand3;
        end
        if (grant_valid) begin
            pop[grant] = 1'b1;
        end
    end

    // Output register and ring pointer; regdest 0 consumes a grant without writing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q      <= SRC_MEM;
            wb_reg_en   <= 1'b0;
            wb_reg_addr <= '0;
            wb_reg_data <= '0;
        end else if (grant_valid) begin
            last_q      <= grant;
            wb_reg_en   <= (head[grant].regdest != '0);
            wb_reg_addr <= head[grant].regdest;
            wb_reg_data <= head[grant].wbvalue;
        end else begin
            wb_reg_en   <= 1'b0;
        end
    end

    // Sticky flag for a push dropped because its FIFO was full and not popped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_overflow <= 1'b0;
        end else if (|(push & full & ~pop)) begin
            wb_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              mul_wb_oper, mul_wb_writereg;
    logic [ADDR_W-1:0] mul_wb_regdest;
    logic [DATA_W-1:0] mul_wb_wbvalue;
    logic              am_wb_oper, am_wb_writereg;
    logic [ADDR_W-1:0] am_wb_regdest;
    logic [DATA_W-1:0] am_wb_wbvalue;
    logic              mem_wb_oper, mem_wb_writereg;
    logic [ADDR_W-1:0] mem_wb_regdest;
    logic [DATA_W-1:0] mem_wb_wbvalue;
    logic              wb_mul_full, wb_am_full, wb_mem_full;
    logic              wb_reg_en;
    logic [ADDR_W-1:0] wb_reg_addr;
    logic [DATA_W-1:0] wb_reg_data;
    logic              wb_busy, wb_overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    wb_arbiter #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mul_wb_oper     (mul_wb_oper),
        .mul_wb_writereg (mul_wb_writereg),
        .mul_wb_regdest  (mul_wb_regdest),
        .mul_wb_wbvalue  (mul_wb_wbvalue),
        .am_wb_oper      (am_wb_oper),
        .am_wb_writereg  (am_wb_writereg),
        .am_wb_regdest   (am_wb_regdest),
        .am_wb_wbvalue   (am_wb_wbvalue),
        .mem_wb_oper     (mem_wb_oper),
        .mem_wb_writereg (mem_wb_writereg),
        .mem_wb_regdest  (mem_wb_regdest),
        .mem_wb_wbvalue  (mem_wb_wbvalue),
        .wb_mul_full     (wb_mul_full),
        .wb_am_full      (wb_am_full),
        .wb_mem_full     (wb_mem_full),
        .wb_reg_en       (wb_reg_en),
        .wb_reg_addr     (wb_reg_addr),
        .wb_reg_data     (wb_reg_data),
        .wb_busy         (wb_busy),
        .wb_overflow     (wb_overflow)
    );

    always #5 clock = ~clock;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        check_eq({tag, ".en"}, 64'(wb_reg_en), 64'(en));
        if (en) begin
            check_eq({tag, ".addr"}, 64'(wb_reg_addr), 64'(addr));
            check_eq({tag, ".data"}, 64'(wb_reg_data), 64'(data));
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in;
        mul_wb_oper = 1'b0; mul_wb_writereg = 1'b0; mul_wb_regdest = '0; mul_wb_wbvalue = '0;
        am_wb_oper  = 1'b0; am_wb_writereg  = 1'b0; am_wb_regdest  = '0; am_wb_wbvalue  = '0;
        mem_wb_oper = 1'b0; mem_wb_writereg = 1'b0; mem_wb_regdest = '0; mem_wb_wbvalue = '0;
    endtask

    task automatic drive_mul(input logic w, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] v);
        mul_wb_oper = 1'b1; mul_wb_writereg = w; mul_wb_regdest = rd; mul_wb_wbvalue = v;
    endtask

    task automatic drive_am(input logic w, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] v);
        am_wb_oper = 1'b1; am_wb_writereg = w; am_wb_regdest = rd; am_wb_wbvalue = v;
    endtask

    task automatic drive_mem(input logic w, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] v);
        mem_wb_oper = 1'b1; mem_wb_writereg = w; mem_wb_regdest = rd; mem_wb_wbvalue = v;
    endtask

    task automatic do_reset;
        clear_in();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        // Reset state
        check_eq("rst.en",    64'(wb_reg_en),   64'd0);
        check_eq("rst.addr",  64'(wb_reg_addr), 64'd0);
        check_eq("rst.data",  64'(wb_reg_data), 64'd0);
        check_eq("rst.busy",  64'(wb_busy),     64'd0);
        check_eq("rst.ovf",   64'(wb_overflow), 64'd0);
        check_eq("rst.full",  64'({wb_mul_full, wb_am_full, wb_mem_full}), 64'd0);
        reset = 1'b0;

        // Single result through AluMisc: two-edge latency, one-cycle pulse.
        drive_am(1'b1, 5'd3, 32'h0000_00AA);
        step();
        clear_in();
        check_eq("single.e1.en", 64'(wb_reg_en), 64'd0);
        check_eq("single.e1.busy", 64'(wb_busy), 64'd1);
        step();
        check_out("single.e2", 1'b1, 5'd3, 32'hAA);
        check_eq("single.e2.busy", 64'(wb_busy), 64'd1);
        step();
        check_eq("single.e3.en", 64'(wb_reg_en), 64'd0);
        check_eq("single.e3.busy", 64'(wb_busy), 64'd0);
        check_eq("single.e3.addr_hold", 64'(wb_reg_addr), 64'd3);

        // Triple collision from reset, twice in a row.
        do_reset();
        for (int unsigned r = 0; r < 2; r++) begin
            drive_mul(1'b1, 5'(1 + 3 * r), 32'h11 + 32'(r) * 32'h33);
            drive_am (1'b1, 5'(2 + 3 * r), 32'h22 + 32'(r) * 32'h33);
            drive_mem(1'b1, 5'(3 + 3 * r), 32'h33 + 32'(r) * 32'h33);
            step();
            clear_in();
            check_eq($sformatf("tri%0d.e1.en", r), 64'(wb_reg_en), 64'd0);
            step();
            check_out($sformatf("tri%0d.mul", r), 1'b1, 5'(1 + 3 * r), 32'h11 + 32'(r) * 32'h33);
            step();
            check_out($sformatf("tri%0d.am", r),  1'b1, 5'(2 + 3 * r), 32'h22 + 32'(r) * 32'h33);
            step();
            check_out($sformatf("tri%0d.mem", r), 1'b1, 5'(3 + 3 * r), 32'h33 + 32'(r) * 32'h33);
            step();
            check_eq($sformatf("tri%0d.idle", r), 64'(wb_reg_en), 64'd0);
        end

        // Fill and backpressure; edge 4 also covers push-while-full with same-cycle grant.
        do_reset();
        drive_mul(1'b1, 5'd9, 32'h101); drive_am(1'b1, 5'd17, 32'h201);
        step();
        check_eq("fill.e1.en", 64'(wb_reg_en), 64'd0);
        check_eq("fill.e1.mfull", 64'(wb_mul_full), 64'd0);
        drive_mul(1'b1, 5'd10, 32'h102); drive_am(1'b1, 5'd18, 32'h202);
        step();
        check_out("fill.e2", 1'b1, 5'd9, 32'h101);
        check_eq("fill.e2.afull", 64'(wb_am_full), 64'd1);
        check_eq("fill.e2.mfull", 64'(wb_mul_full), 64'd0);
        clear_in();
        drive_mul(1'b1, 5'd11, 32'h103);
        step();
        check_out("fill.e3", 1'b1, 5'd17, 32'h201);
        check_eq("fill.e3.mfull", 64'(wb_mul_full), 64'd1);
        check_eq("fill.e3.afull", 64'(wb_am_full), 64'd0);
        drive_mul(1'b1, 5'd12, 32'h104);
        step();
        check_out("fill.e4", 1'b1, 5'd10, 32'h102);
        check_eq("fill.e4.mfull", 64'(wb_mul_full), 64'd1);
        check_eq("fill.e4.ovf", 64'(wb_overflow), 64'd0);
        drive_mul(1'b1, 5'd13, 32'h105);
        step();
        clear_in();
        check_out("fill.e5", 1'b1, 5'd18, 32'h202);
        check_eq("fill.e5.ovf", 64'(wb_overflow), 64'd1);
        step();
        check_out("fill.e6", 1'b1, 5'd11, 32'h103);
        check_eq("fill.e6.mfull", 64'(wb_mul_full), 64'd0);
        step();
        check_out("fill.e7", 1'b1, 5'd12, 32'h104);
        step();
        check_eq("fill.e8.en", 64'(wb_reg_en), 64'd0);
        check_eq("fill.e8.busy", 64'(wb_busy), 64'd0);
        check_eq("fill.e8.ovf", 64'(wb_overflow), 64'd1);

        // Non-writes: a store from Mem and a regdest-0 result from AluMisc.
        do_reset();
        check_eq("nw.ovf_cleared", 64'(wb_overflow), 64'd0);
        drive_mem(1'b0, 5'd7, 32'h77);
        drive_am(1'b1, 5'd0, 32'h0000_FFFF);
        step();
        clear_in();
        check_eq("nw.e1.en", 64'(wb_reg_en), 64'd0);
        check_eq("nw.e1.busy", 64'(wb_busy), 64'd1);
        step();
        check_eq("nw.e2.en", 64'(wb_reg_en), 64'd0);
        check_eq("nw.e2.busy", 64'(wb_busy), 64'd0);
        step();
        check_eq("nw.e3.en", 64'(wb_reg_en), 64'd0);

        // Reset mid-stream with three entries buffered and a write in flight.
        do_reset();
        drive_mul(1'b1, 5'd1, 32'h11); drive_am(1'b1, 5'd2, 32'h22); drive_mem(1'b1, 5'd3, 32'h33);
        step();
        clear_in();
        drive_mul(1'b1, 5'd4, 32'h44);
        step();
        clear_in();
        check_out("mid.e2", 1'b1, 5'd1, 32'h11);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid.rst.en",   64'(wb_reg_en),   64'd0);
        check_eq("mid.rst.busy", 64'(wb_busy),     64'd0);
        check_eq("mid.rst.addr", 64'(wb_reg_addr), 64'd0);
        check_eq("mid.rst.data", 64'(wb_reg_data), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("mid.post%0d.en", i), 64'(wb_reg_en), 64'd0);
            check_eq($sformatf("mid.post%0d.busy", i), 64'(wb_busy), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
